// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/acknowledge bus between the memory stage and the cache.
// Only the request side (master) is driven by mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [DATA_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one cache access per instruction, stalls the
// front of the pipeline until dhit, and maintains the MEM/WB latch.
module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int WSEL_W = 5
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                flush,
  input  logic                advance_i,
  input  logic [DATA_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdat_i,
  input  logic                dREN_i,
  input  logic                dWEN_i,
  input  logic                reg_wr_i,
  input  logic [WSEL_W-1:0]   wsel_i,
  input  logic                halt_i,
  mem_access_ctrl_if.master   dcache,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   wb_result,
  output logic [WSEL_W-1:0]   wb_wsel,
  output logic                wb_WEN,
  output logic                wb_halt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] capture_reg;
  logic [DATA_W-1:0] result_next;
  logic              req;

  // DONE means the access already completed while EX/MEM was frozen by
  // another hazard; re-issuing it would duplicate a store.
  assign req = (dREN_i | dWEN_i) & ~halt_i & (state_reg != DONE);

  assign dcache.dmemREN   = req & dREN_i;
  assign dcache.dmemWEN   = req & dWEN_i & ~dREN_i;
  assign dcache.dmemaddr  = addr_i;
  assign dcache.dmemstore = wdat_i;
  assign mem_stall        = req & ~dcache.dhit;

  always_comb begin
    state_next  = state_reg;
    result_next = addr_i;
    case (state_reg)
      IDLE: begin
        if (req & ~dcache.dhit)
          state_next = BUSY;
        else if (req & dcache.dhit & ~advance_i)
          state_next = DONE;
      end
      BUSY: begin
        if (dcache.dhit)
          state_next = advance_i ? IDLE : DONE;
      end
      DONE: begin
        if (advance_i)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The cache no longer drives valid data once the access has finished.
    if (state_reg == DONE) begin
      if (dREN_i)
        result_next = capture_reg;
    end else if (dcache.dhit & dREN_i) begin
      result_next = dcache.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      capture_reg <= '0;
      wb_result   <= '0;
      wb_wsel     <= '0;
      wb_WEN      <= 1'b0;
      wb_halt     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (req & dREN_i & dcache.dhit)
        capture_reg <= dcache.dmemload;

      if (flush) begin
        wb_result <= '0;
        wb_wsel   <= '0;
        wb_WEN    <= 1'b0;
      end else if (mem_stall) begin
        wb_WEN <= 1'b0;
      end else begin
        wb_result <= result_next;
        wb_wsel   <= wsel_i;
        wb_WEN    <= reg_wr_i;
      end

      // Sticky until reset so write-back can signal the halt even if a
      // later flush wipes the latch.
      if (halt_i & ~mem_stall)
        wb_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl: the driver pushes expected
// per-cycle outputs into a scoreboard, a negedge monitor pops and compares.
module tb_mem_access_ctrl;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        advance_i;
  logic [31:0] addr_i;
  logic [31:0] wdat_i;
  logic        dREN_i;
  logic        dWEN_i;
  logic        reg_wr_i;
  logic [4:0]  wsel_i;
  logic        halt_i;
  logic        mem_stall;
  logic [31:0] wb_result;
  logic [4:0]  wb_wsel;
  logic        wb_WEN;
  logic        wb_halt;

  mem_access_ctrl_if #(.DATA_W(32)) dif ();

  mem_access_ctrl #(.DATA_W(32), .WSEL_W(5)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .advance_i (advance_i),
    .addr_i    (addr_i),
    .wdat_i    (wdat_i),
    .dREN_i    (dREN_i),
    .dWEN_i    (dWEN_i),
    .reg_wr_i  (reg_wr_i),
    .wsel_i    (wsel_i),
    .halt_i    (halt_i),
    .dcache    (dif),
    .mem_stall (mem_stall),
    .wb_result (wb_result),
    .wb_wsel   (wb_wsel),
    .wb_WEN    (wb_WEN),
    .wb_halt   (wb_halt)
  );

  typedef struct {
    int          idx;
    logic        ren;
    logic        wen;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] res;
    logic [4:0]  wsel;
    logic        wbwen;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Inputs apply for one cycle; expectations are the outputs seen during
  // that cycle (wb_* reflect the previous edge).
  task automatic step(
    input logic rstn, fl, adv, ren, wen, rw, hlt, hit,
    input logic [31:0] addr, wdat, load, input logic [4:0] wsel,
    input logic e_ren, e_wen, e_stall,
    input logic [31:0] e_res, input logic [4:0] e_wsel, input logic e_wbwen, e_halt);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = rstn; flush = fl; advance_i = adv; dREN_i = ren; dWEN_i = wen;
    reg_wr_i = rw; halt_i = hlt; dif.dhit = hit; addr_i = addr; wdat_i = wdat;
    dif.dmemload = load; wsel_i = wsel;
    e.idx = pushed; e.ren = e_ren; e.wen = e_wen; e.stall = e_stall;
    e.addr = addr; e.store = wdat; e.res = e_res; e.wsel = e_wsel;
    e.wbwen = e_wbwen; e.halt = e_halt;
    sb.push_back(e);
    pushed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        $display("cycle %0d: ren=%b wen=%b stall=%b wb_result=%h wb_wsel=%0d wb_WEN=%b wb_halt=%b",
                 e.idx, dif.dmemREN, dif.dmemWEN, mem_stall, wb_result, wb_wsel, wb_WEN, wb_halt);
        chk("dmemREN",   e.idx, {31'd0, dif.dmemREN}, {31'd0, e.ren});
        chk("dmemWEN",   e.idx, {31'd0, dif.dmemWEN}, {31'd0, e.wen});
        chk("mem_stall", e.idx, {31'd0, mem_stall},   {31'd0, e.stall});
        chk("dmemaddr",  e.idx, dif.dmemaddr,  e.addr);
        chk("dmemstore", e.idx, dif.dmemstore, e.store);
        chk("wb_result", e.idx, wb_result,     e.res);
        chk("wb_wsel",   e.idx, {27'd0, wb_wsel}, {27'd0, e.wsel});
        chk("wb_WEN",    e.idx, {31'd0, wb_WEN},  {31'd0, e.wbwen});
        chk("wb_halt",   e.idx, {31'd0, wb_halt}, {31'd0, e.halt});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    nRST = 1'b0; flush = 1'b0; advance_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0;
    reg_wr_i = 1'b0; halt_i = 1'b0; addr_i = '0; wdat_i = '0; wsel_i = '0;
    dif.dhit = 1'b0; dif.dmemload = '0;

    //   rst fl adv ren wen rw hlt hit  addr     wdat          load           wsel   eREN eWEN eSTL  eRES           eWSEL eWBWEN eHALT
    step(0, 0, 0,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0,          5'd0, 0,     0);
    // load, immediate hit
    step(1, 0, 1,  1,  0,  1, 0,  1,   32'h100, 32'h0,        32'hDEADBEEF,   5'd5,  1,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'hDEADBEEF,   5'd5, 1,     0);
    // store, hit after 3 miss cycles
    step(1, 0, 0,  0,  1,  0, 0,  0,   32'h200, 32'h12345678, 32'h0,          5'd0,  0,   1,   1,    32'h0,          5'd0, 0,     0);
    step(1, 0, 0,  0,  1,  0, 0,  0,   32'h200, 32'h12345678, 32'h0,          5'd0,  0,   1,   1,    32'h0,          5'd0, 0,     0);
    step(1, 0, 0,  0,  1,  0, 0,  0,   32'h200, 32'h12345678, 32'h0,          5'd0,  0,   1,   1,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  0,  1,  0, 0,  1,   32'h200, 32'h12345678, 32'h0,          5'd0,  0,   1,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h200,        5'd0, 0,     0);
    // load hit held in DONE for extra cycles, cache data changes meanwhile
    step(1, 0, 0,  1,  0,  1, 0,  1,   32'h300, 32'h0,        32'hCAFEF00D,   5'd7,  1,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 0,  1,  0,  1, 0,  0,   32'h300, 32'h0,        32'h11111111,   5'd7,  0,   0,   0,    32'hCAFEF00D,   5'd7, 1,     0);
    step(1, 0, 0,  1,  0,  1, 0,  1,   32'h300, 32'h0,        32'h22222222,   5'd7,  0,   0,   0,    32'hCAFEF00D,   5'd7, 1,     0);
    step(1, 0, 1,  1,  0,  1, 0,  0,   32'h300, 32'h0,        32'h33333333,   5'd7,  0,   0,   0,    32'hCAFEF00D,   5'd7, 1,     0);
    step(1, 0, 1,  1,  0,  1, 0,  1,   32'h400, 32'h0,        32'hA5A5A5A5,   5'd3,  1,   0,   0,    32'hCAFEF00D,   5'd7, 1,     0);
    // non-memory op then flush
    step(1, 0, 1,  0,  0,  1, 0,  0,   32'h55,  32'h0,        32'h0,          5'd9,  0,   0,   0,    32'hA5A5A5A5,   5'd3, 1,     0);
    step(1, 1, 1,  0,  0,  1, 0,  0,   32'h66,  32'h0,        32'h0,          5'd10, 0,   0,   0,    32'h55,         5'd9, 1,     0);
    // halt with a load pending, sticky through flush
    step(1, 0, 1,  1,  0,  0, 1,  0,   32'h500, 32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 1, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h500,        5'd0, 0,     1);
    step(1, 0, 1,  0,  0,  1, 0,  0,   32'h77,  32'h0,        32'h0,          5'd2,  0,   0,   0,    32'h0,          5'd0, 0,     1);
    // reset in BUSY, then a fresh load
    step(1, 0, 0,  1,  0,  1, 0,  0,   32'h600, 32'h0,        32'h0,          5'd4,  1,   0,   1,    32'h77,         5'd2, 1,     1);
    step(1, 0, 0,  1,  0,  1, 0,  0,   32'h600, 32'h0,        32'h0,          5'd4,  1,   0,   1,    32'h77,         5'd2, 0,     1);
    step(0, 0, 0,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  1,  0,  1, 0,  1,   32'h700, 32'h0,        32'h0BADCAFE,   5'd6,  1,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0BADCAFE,   5'd6, 1,     0);
    // load and store both set: load wins; miss then hit into DONE
    step(1, 0, 0,  1,  1,  1, 0,  0,   32'h800, 32'h99,       32'h0,          5'd8,  1,   0,   1,    32'h0,          5'd0, 0,     0);
    step(1, 0, 0,  1,  1,  1, 0,  1,   32'h800, 32'h99,       32'h13579BDF,   5'd8,  1,   0,   0,    32'h0,          5'd0, 0,     0);
    step(1, 0, 1,  1,  1,  1, 0,  0,   32'h800, 32'h99,       32'h0,          5'd8,  0,   0,   0,    32'h13579BDF,   5'd8, 1,     0);
    // stray dhit with no request is ignored
    step(1, 0, 1,  0,  0,  0, 0,  1,   32'h0,   32'h0,        32'hFFFFFFFF,   5'd0,  0,   0,   0,    32'h13579BDF,   5'd8, 1,     0);
    step(1, 0, 1,  0,  0,  0, 0,  0,   32'h0,   32'h0,        32'h0,          5'd0,  0,   0,   0,    32'h0,          5'd0, 0,     0);

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge CLK);
    checks++;
    if (sb.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL scoreboard_drain: popped %0d expected %0d", popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller that consumes the EX/MEM pipeline latch outputs and drives the data-cache request/acknowledge handshake. It issues exactly one load or store per instruction, stalls the front of the pipeline until the cache acknowledges, and writes a MEM/WB latch that feeds write-back. It sits between the EX/MEM latch and the write-back stage.

## Interface
- DATA_W, 32, data and address width
- WSEL_W, 5, register-select width
---
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of the MEM/WB latch
- advance_i  in  1  EX/MEM latch loads a new instruction on this edge (its execute_en)
- addr_i  in  DATA_W  ALU result (memory address, or write-back value for non-memory ops)
- wdat_i  in  DATA_W  store data
- dREN_i / dWEN_i  in  1  load / store request
- reg_wr_i  in  1  register write enable
- wsel_i  in  WSEL_W  destination register
- halt_i  in  1  halt instruction
- dhit  in  1  cache acknowledge; load data is valid in the same cycle
- dmemload  in  DATA_W  load data
- dmemREN / dmemWEN  out  1  cache read / write strobe
- dmemaddr, dmemstore  out  DATA_W  request address / store data
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- wb_result  out  DATA_W  write-back value
- wb_wsel  out  WSEL_W  write-back destination register
- wb_WEN  out  1  write-back enable
- wb_halt  out  1  sticky halt

## Operation
- FSM states: IDLE, BUSY, DONE.
- `req = (dREN_i | dWEN_i) & ~halt_i & (state != DONE)`.
- Request outputs:
  - dmemREN = req & dREN_i
  - dmemWEN = req & dWEN_i & ~dREN_i (a load wins if both are set)
  - dmemaddr = addr_i; dmemstore = wdat_i, driven combinationally
- `mem_stall = req & ~dhit`.
- State transitions:
  - IDLE: req & ~dhit → BUSY. req & dhit & ~advance_i → DONE. Otherwise stay in IDLE.
  - BUSY: dhit & advance_i → IDLE. dhit & ~advance_i → DONE. ~dhit → stay in BUSY and hold the request.
  - DONE: no request is issued. advance_i → IDLE. This blocks a duplicate access when some other hazard freezes EX/MEM.
- MEM/WB latch, updated each edge when ~mem_stall:
  - wb_result = dhit & dREN_i ? dmemload : addr_i
  - wb_wsel = wsel_i; wb_WEN = reg_wr_i
- In DONE, load data is taken from an internal capture register loaded on dhit, not from dmemload.
- While mem_stall = 1, a bubble is inserted: wb_WEN ← 0; wb_result and wb_wsel hold.
- Halt handling:
  - wb_halt ← 1 when halt_i is present and ~mem_stall.
  - wb_halt stays 1 until nRST; flush does not clear it.
- flush (synchronous) has priority over the latch update:
  - wb_result, wb_wsel and wb_WEN ← 0.
  - FSM state is unaffected; an outstanding access completes.
- nRST low clears everything:
  - state = IDLE; capture register = 0.
  - wb_result, wb_wsel, wb_WEN, wb_halt = 0.
  - Request outputs follow the inputs, which are zero while the upstream latch is in reset.

## Timing
- Cache hit on the request cycle: zero stall. wb_result holds the load data after the next CLK edge.
- Miss acknowledged after N cycles: mem_stall is high for exactly N cycles. MEM/WB updates on the edge of the dhit cycle.
- Stores: identical timing; wb_WEN follows reg_wr_i (normally 0).
- Non-memory ops: no stall; MEM/WB updates every edge.
- dhit while no request is pending is ignored.
- Reset asserted mid-BUSY: outputs clear asynchronously. The cache interface is expected to be reset by the same nRST.

## Test plan
- Load, addr 0x100, dhit in the same cycle, dmemload 0xDEADBEEF, wsel 5 → dmemREN = 1 for one cycle, mem_stall = 0; next edge: wb_result = 0xDEADBEEF, wb_wsel = 5, wb_WEN = 1.
- Store, addr 0x200, wdat 0x12345678, dhit after 3 cycles → dmemWEN high 4 cycles, mem_stall high 3 cycles, wb_WEN = 0 throughout, one request only.
- Load hit with advance_i = 0 for 2 extra cycles → FSM goes to DONE, dmemREN = 0 in those cycles, wb_result holds the captured load data; advance_i = 1 → IDLE.
- Non-memory op, addr_i 0x55, reg_wr 1, wsel 9 → no stall; next edge wb_result = 0x55, wb_WEN = 1; flush on the following cycle → wb_result/wb_wsel/wb_WEN = 0.
- halt_i with dREN_i = 1 → no dmemREN; wb_halt = 1 next edge and remains 1 through a flush; nRST low → 0.
- nRST pulse while BUSY → state IDLE, all wb_* = 0; after release, a new load with an immediate dhit completes normally.
